// File: rtl/mcseq.sv
// Microcode sequencer: steps a 6-bit ROM address on each rising edge of the clk
// strobe, decoding next-address modes and publishing the datapath control field.
module mcseq (
    input  logic        sys_clk,
    input  logic        resetl,
    input  logic        clk,
    input  logic [0:26] z,
    input  logic [0:3]  cond,
    input  logic        go,
    output logic [0:5]  a,
    output logic [0:14] ctl,
    output logic        uop,
    output logic        stall,
    output logic        ovf,
    output logic        und
);

    localparam int unsigned AW    = 6;
    localparam int unsigned CW    = 15;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 3;
    localparam int unsigned PTRW  = 2;

    localparam logic [1:0] OP_NEXT    = 2'b00;
    localparam logic [1:0] OP_JUMP    = 2'b01;
    localparam logic [1:0] OP_BRANCH  = 2'b10;
    localparam logic [1:0] OP_CALLRET = 2'b11;

    logic            r_clk_prev;
    logic            r_stb_d;
    logic [AW-1:0]   r_a;
    logic [CW-1:0]   r_ctl;
    logic            r_uop;
    logic            r_stall;
    logic            r_ovf;
    logic            r_und;
    logic [AW-1:0]   r_stk [DEPTH];
    logic [CNTW-1:0] r_cnt;

    logic            w_stb;
    logic [1:0]      w_op;
    logic [AW-1:0]   w_tgt;
    logic [1:0]      w_sel;
    logic            w_sense;
    logic            w_hold;
    logic            w_cond;
    logic [AW-1:0]   w_inc;
    logic [PTRW-1:0] w_top;
    logic            w_full;
    logic            w_empty;
    logic [AW-1:0]   w_a_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_set_ovf;
    logic            w_set_und;

    // Step strobe: rising edge of clk as seen in sys_clk, same detector the ROM uses
    assign w_stb   = ~r_clk_prev & clk;

    assign w_op    = z[0:1];
    assign w_tgt   = z[2:7];
    assign w_sel   = z[8:9];
    assign w_sense = z[10];
    assign w_hold  = z[11] & ~go;
    assign w_cond  = cond[w_sel];
    assign w_inc   = AW'(r_a + AW'(1));
    assign w_top   = PTRW'(r_cnt - CNTW'(1));
    assign w_full  = (r_cnt == CNTW'(DEPTH));
    assign w_empty = (r_cnt == CNTW'(0));

    // Next-address selection and stack/flag requests for the executing word
    always_comb begin
        w_a_nxt   = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_und = 1'b0;
        case (w_op)
            OP_NEXT: begin
                w_a_nxt = w_inc;
            end
            OP_JUMP: begin
                w_a_nxt = w_tgt;
            end
            OP_BRANCH: begin
                if (w_cond ^ w_sense) begin
                    w_a_nxt = w_tgt;
                end
            end
            OP_CALLRET: begin
                if (!w_sense) begin
                    w_a_nxt = w_tgt;
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end else if (w_empty) begin
                    w_a_nxt   = '0;
                    w_set_und = 1'b1;
                end else begin
                    w_a_nxt = r_stk[w_top];
                    w_pop   = 1'b1;
                end
            end
            default: begin
                w_a_nxt = w_inc;
            end
        endcase
    end

    // Sequencer state; acts only on the cycle after the strobe, when z is valid
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            r_clk_prev <= 1'b1;
            r_stb_d    <= 1'b0;
            r_a        <= '0;
            r_ctl      <= '0;
            r_uop      <= 1'b0;
            r_stall    <= 1'b0;
            r_ovf      <= 1'b0;
            r_und      <= 1'b0;
            r_cnt      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stk[i] <= '0;
            end
        end else begin
            r_clk_prev <= clk;
            r_stb_d    <= w_stb;
            r_uop      <= 1'b0;
            if (r_stb_d) begin
                r_stall <= w_hold;
                if (!w_hold) begin
                    r_a   <= w_a_nxt;
                    r_ctl <= z[12:26];
                    r_uop <= 1'b1;
                    if (w_push) begin
                        r_stk[r_cnt[PTRW-1:0]] <= w_inc;
                        r_cnt <= CNTW'(r_cnt + CNTW'(1));
                    end
                    if (w_pop) begin
                        r_cnt <= CNTW'(r_cnt - CNTW'(1));
                    end
                    if (w_set_ovf) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_set_und) begin
                        r_und <= 1'b1;
                    end
                end
            end
        end
    end

    assign a     = r_a;
    assign ctl   = r_ctl;
    assign uop   = r_uop;
    assign stall = r_stall;
    assign ovf   = r_ovf;
    assign und   = r_und;

endmodule

// File: doc/mcseq.md
# mcseq

Microcode sequencer that drives the 6-bit address of the 64×27 microcode ROM and consumes the 27-bit word it returns. Each `clk` step it decodes the next-address field of the current microword, selects the next address, and publishes the datapath control field. Supported next-address modes are increment, jump, conditional branch, call/return on a 4-deep return stack, and wait-for-go. It runs in the `sys_clk` domain and samples `clk` as a step strobe, the same way the ROM does.

## Interface

- No parameters. Widths are fixed: address 6, microword 27, stack depth 4.
- `sys_clk`  in  1  system clock; the only clock.
- `resetl`  in  1  synchronous active-low reset, sampled on rising `sys_clk`.
- `clk`  in  1  step clock, sampled as data. A rising edge seen in `sys_clk` is one microcode step.
- `z[0:26]`  in  27  microword from the ROM, valid from one `sys_clk` after each step strobe.
- `cond[0:3]`  in  4  branch condition inputs.
- `go`  in  1  releases a wait microword.
- `a[0:5]`  out  6  microcode address to the ROM (registered).
- `ctl[0:14]`  out  15  datapath control, a registered copy of `z[12:26]` of the executing word.
- `uop`  out  1  one-`sys_clk` pulse each time `ctl` is loaded.
- `stall`  out  1  high while a wait word holds because `go` is low.
- `ovf`  out  1  sticky: a call was made with the stack full.
- `und`  out  1  sticky: a return was made with the stack empty.

## Operation

Microword fields (ascending bit numbering):
- `z[0:1]` op: 00 = next (`a+1`), 01 = jump to `z[2:7]`, 10 = branch, 11 = call/return.
- `z[2:7]` target address.
- `z[8:9]` condition select, index into `cond`.
- `z[10]` sense. For branch: 1 inverts the selected condition. For op 11: 0 = call, 1 = return.
- `z[11]` wait.
- `z[12:26]` control field, passed to `ctl`.

Next-address rules:
- Branch: target is `z[2:7]` if `cond[z[8:9]] ^ z[10]`, otherwise `a+1`.
- Call: push `a+1` (mod 64) and jump to `z[2:7]`.
  - Stack full (4 entries): the push is dropped, the jump still happens, `ovf` is set.
- Return: pop into `a`.
  - Stack empty: `a` becomes 0, `und` is set.
- Wait: `z[11]=1` with `go=0` holds `a`, `ctl`, and the stack, and asserts `stall`.
  - When `go=1` at a step, the op executes normally.
- Increment wraps: 63+1 = 0.

Stack: 4×6 LIFO with a 3-bit occupancy count (0–4). Only call and return modify it.

## Timing

- Edge detect: `clk_prev <= clk` every `sys_clk`; `stb = ~clk_prev & clk`. This matches the ROM, so the ROM latches `rom[a]` on the same `sys_clk` edge that sees `stb`.
- `stb_d` is `stb` delayed one `sys_clk`. On `stb_d` the sequencer registers the new `a`, loads `ctl <= z[12:26]` (unless waiting), pulses `uop`, and updates the stack and flags.
- Constraint: `clk` must stay high ≥2 and low ≥2 `sys_clk` cycles, so `a` is stable before the next `stb`.
- Latency: one microword per `clk` period. The address chosen at step k is fetched at step k+1.
- `cond` and `go` are sampled on the `stb_d` cycle only.
- `stall` is a registered output: it updates on `stb_d` and stays valid until the next `stb_d`.
- Reset values (`resetl=0` at any time, mid-step included): `a=0`, `ctl=0`, `uop=0`, `stall=0`, `ovf=0`, `und=0`, stack count 0, and `clk_prev=1`.
  - `clk_prev=1` means a `clk` already high at release does not count as a step.
- The first `stb` after reset fetches `rom[0]`. No sequencer action happens before the first `stb_d`.
- `clk` held static: no `stb`, so all state holds.

## Test plan

- Linear fetch: words at 0..3 with op 00 and `ctl` = 1,2,3,4 → `a` goes 1,2,3,4 on successive `stb_d`; `ctl` goes 1,2,3,4; exactly one `uop` per step.
- Wrap and jump: word 63 op 00 → `a=0`. Word 5 op 01 with target 40 → next `a=40`.
- Branch: `z[8:9]=2`, `z[10]=0`, target 20. With `cond[2]=1` → `a=20`. With `cond[2]=0` → `a=a+1`. With `z[10]=1` and `cond[2]=0` → `a=20`.
- Call/return: nested calls from 10, 20, 30, 40, then a fifth call from 50 → `ovf=1` and the jump is taken. Five returns → `a` = 41, 31, 21, 11, then 0 with `und=1`.
- Wait: `z[11]=1` with `go=0` for 3 steps → `a` and `ctl` frozen, `stall=1`, no `uop`. Raise `go` → `stall=0` and the op executes on that step.
- Reset mid-run: assert `resetl=0` while `a=37` and the stack count is 2 → next `sys_clk` has `a=0`, flags 0, count 0. The first `clk` edge after release fetches word 0.
